// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types, widths and default timing constants for the
//                four-key debounce/scan block.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

  // Debounce FSM encoding
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  localparam int CNT_WIDTH = 20;
  localparam int KEY_NUM   = 4;
  localparam int REP_WIDTH = 25;

  // 20 ms debounce at 50 MHz
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_DEF    = 20'd999_999;
  // Auto-repeat: 0.5 s initial delay, 0.1 s period at 50 MHz
  localparam logic [REP_WIDTH-1:0] REPEAT_DLY_DEF = 25'd24_999_999;
  localparam logic [REP_WIDTH-1:0] REPEAT_PER_DEF = 25'd4_999_999;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [1:0] lowest_index(input logic [KEY_NUM-1:0] vec);
    lowest_index = 2'd0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (vec[i]) lowest_index = 2'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One push-button channel: 2-flop synchronizer, debounce FSM
//                with stability counter, one-cycle press pulse. With the
//                KEY_REPEAT_EN macro defined, a held key re-pulses after
//                REPEAT_DLY+1 cycles and then every REPEAT_PER+1 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
  import key_pkg::*;
#(
  // CNT_MAX must be at least 1: the first stable sample is counted on entry
  // to the wait state, so the counter starts at 1.
  parameter logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_MAX_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [REP_WIDTH-1:0] REPEAT_DLY = REPEAT_DLY_DEF,
  parameter logic [REP_WIDTH-1:0] REPEAT_PER = REPEAT_PER_DEF
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,   // raw, active-low, asynchronous
  output logic state_o,   // debounced level, 1 = pressed
  output logic press_o    // one-cycle press pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           sync_q;
  key_fsm_e             state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_q, press_d;
  logic                 key_s;       // synchronized key, active-low
  logic                 debounce_hit;
  logic                 repeat_hit;

  assign key_s = sync_q[1];

  // Two-flop synchronizer; resets to released so reset never fakes a press
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], key_n_i};
  end

  // FSM, stability counter and press pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Next state: a level change is accepted after CNT_MAX+1 consecutive
  // samples at the new level; any bounce returns to the settled state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    debounce_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d      = PRESSED;
          cnt_d        = '0;
          debounce_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    press_d = debounce_hit | repeat_hit;
  end

`ifdef KEY_REPEAT_EN
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

  logic [REP_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                 rep_init_q, rep_init_d;  // 1 = still in initial delay

  // Repeat counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep_cnt_q  <= '0;
      rep_init_q <= 1'b1;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_init_q <= rep_init_d;
    end
  end

  // Counts only while settled in PRESSED; a release bounce pauses it and
  // returning to IDLE (or never having left it) restarts the sequence.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    rep_init_d = rep_init_q;
    repeat_hit = 1'b0;
    if (state_q == PRESSED && !key_s) begin
      if (rep_cnt_q == (rep_init_q ? REPEAT_DLY : REPEAT_PER)) begin
        repeat_hit = 1'b1;
        rep_cnt_d  = '0;
        rep_init_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end else if (state_q == IDLE || state_q == PRESS_WAIT) begin
      rep_cnt_d  = '0;
      rep_init_d = 1'b1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign state_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan
//  Description : Four active-low push-buttons debounced into level, press
//                pulses and a registered lowest-index key_code/key_valid
//                event. Optional macro KEY_REPEAT_EN adds auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module key_scan
  import key_pkg::*;
#(
  parameter logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_MAX_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [REP_WIDTH-1:0] REPEAT_DLY = REPEAT_DLY_DEF,
  parameter logic [REP_WIDTH-1:0] REPEAT_PER = REPEAT_PER_DEF
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [1:0]         key_code,
  output logic               key_valid
);

  logic [1:0] key_code_q;
  logic       key_valid_q;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce #(
      .CNT_MAX   (CNT_MAX)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
`endif
    ) u_key (
      .clk_i  (sys_clk),
      .rst_i  (sys_rst),
      .key_n_i(key_in[i]),
      .state_o(key_state[i]),
      .press_o(key_press[i])
    );
  end

  // Priority encoder: lowest pressed index wins, code holds between events
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 2'd0;
    end else begin
      key_valid_q <= |key_press;
      if (|key_press) key_code_q <= lowest_index(key_press);
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_scan
//  Description : Self-checking bench for key_scan (CNT_MAX=9; with
//                KEY_REPEAT_EN also REPEAT_DLY=29, REPEAT_PER=9).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_scan;

  localparam int CMAX = 9;
`ifdef KEY_REPEAT_EN
  localparam int RDLY = 29;
  localparam int RPER = 9;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] key_in  = 4'hF;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [1:0] key_code;
  logic       key_valid;

  int n_cmp = 0;
  int n_bad = 0;

  key_scan #(
    .CNT_MAX   (20'd9)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DLY(25'd29),
    .REPEAT_PER(25'd9)
`endif
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------------------------------------------------------------
  // Reference model: each key's debounced level flips once the delayed
  // input has disagreed with it for CMAX+1 consecutive clock samples.
  // ---------------------------------------------------------------------
  logic [3:0] m_d1, m_d2;     // key_in delayed by one and two clocks
  logic [3:0] m_level, m_press;
  logic       m_valid;
  logic [1:0] m_code;
  int         m_run [4];
  int         m_age [4];      // settled-pressed samples since last pulse
  bit         m_first [4];

  task automatic model_reset();
    m_d1 = 4'hF; m_d2 = 4'hF; m_level = 4'h0; m_press = 4'h0;
    m_valid = 1'b0; m_code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_age[i] = 0; m_first[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [3:0] prev;
    logic [3:0] nxt;
    prev = m_press;
    nxt  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      bit pressed_now;
      int run_before;
      pressed_now = ~m_d2[i];
      run_before  = m_run[i];
      if (pressed_now != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == CMAX + 1) begin
          m_level[i] = pressed_now;
          m_run[i]   = 0;
          m_age[i]   = 0;
          m_first[i] = 1'b1;
          if (pressed_now) nxt[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
`ifdef KEY_REPEAT_EN
        if (m_level[i] && run_before == 0) begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == (m_first[i] ? RDLY + 1 : RPER + 1)) begin
            nxt[i]     = 1'b1;
            m_age[i]   = 0;
            m_first[i] = 1'b0;
          end
        end
`endif
      end
    end
    m_press = nxt;
    m_valid = |prev;
    for (int i = 3; i >= 0; i--) if (prev[i]) m_code = 2'(i);
    m_d2 = m_d1;
    m_d1 = key_in;
  endtask

  // Advance one clock; returns at the following falling edge
  task automatic tick();
    @(posedge sys_clk);
    if (sys_rst) model_reset();
    else         model_step();
    @(negedge sys_clk);
  endtask

  task automatic release_all();
    key_in = 4'hF;
    repeat (30) tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    int first;
    logic [3:0] got;
    key_in  = 4'b1110;
    sys_rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({key_state, key_press, key_code, key_valid} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_immediate: got state=%b press=%b code=%0d valid=%b, want all 0",
               key_state, key_press, key_code, key_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({key_state, key_press, key_code, key_valid} !== 11'd0) begin
        n_bad++;
        $display("FAIL reset_hold: got state=%b press=%b code=%0d valid=%b, want all 0",
                 key_state, key_press, key_code, key_valid);
      end
    end
    sys_rst = 1'b0;
    first = -1;
    got   = 4'h0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (key_press !== 4'h0 && first < 0) begin
        first = c;
        got   = key_press;
      end
    end
    n_cmp++;
    if (first != 12) begin
      n_bad++;
      $display("FAIL reset_release_latency: got %0d cycles, want 12", first);
    end
    n_cmp++;
    if (got !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_release_press: got %b, want 0001", got);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_clean_press();
    int fp, fv, npulse;
    logic [3:0] pv;
    logic [1:0] cv;
    release_all();
    key_in[1] = 1'b0;
    fp = -1; fv = -1; npulse = 0; pv = 4'h0; cv = 2'd0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (key_press !== 4'h0) begin
        npulse++;
        if (fp < 0) begin fp = c; pv = key_press; end
      end
      if (key_valid === 1'b1 && fv < 0) begin fv = c; cv = key_code; end
    end
    n_cmp++;
    if (fp != 12 || pv !== 4'b0010 || npulse != 1) begin
      n_bad++;
      $display("FAIL clean_press: got cycle=%0d press=%b pulses=%0d, want 12 0010 1", fp, pv, npulse);
    end
    n_cmp++;
    if (fv != 13 || cv !== 2'd1) begin
      n_bad++;
      $display("FAIL clean_press_code: got valid cycle=%0d code=%0d, want 13 1", fv, cv);
    end
    n_cmp++;
    if (key_state !== 4'b0010) begin
      n_bad++;
      $display("FAIL clean_press_state: got %b, want 0010", key_state);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_bounce();
    int events;
    release_all();
    events = 0;
    key_in[2] = 1'b0; repeat (5) tick();
    key_in[2] = 1'b1; repeat (3) tick();
    key_in[2] = 1'b0; repeat (8) tick();
    key_in[2] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (key_press !== 4'h0 || key_state !== 4'h0 || key_valid !== 1'b0) events++;
    end
    n_cmp++;
    if (events != 0) begin
      n_bad++;
      $display("FAIL bounce_reject: got %0d cycles with activity, want 0", events);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_simultaneous();
    int fp, nvalid, npulse;
    logic [3:0] pv;
    logic [1:0] cv;
    release_all();
    key_in = 4'b0101;
    fp = -1; nvalid = 0; npulse = 0; pv = 4'h0; cv = 2'd0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (key_press !== 4'h0) begin
        npulse++;
        if (fp < 0) begin fp = c; pv = key_press; end
      end
      if (key_valid === 1'b1) begin nvalid++; cv = key_code; end
    end
    n_cmp++;
    if (fp != 12 || pv !== 4'b1010 || npulse != 1) begin
      n_bad++;
      $display("FAIL simultaneous_press: got cycle=%0d press=%b pulses=%0d, want 12 1010 1", fp, pv, npulse);
    end
    n_cmp++;
    if (nvalid != 1 || cv !== 2'd1) begin
      n_bad++;
      $display("FAIL simultaneous_encode: got valid pulses=%0d code=%0d, want 1 1", nvalid, cv);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_release();
    int fc, diff;
    key_in = 4'b0111;
    repeat (20) tick();
    n_cmp++;
    if (key_state !== 4'b1000) begin
      n_bad++;
      $display("FAIL release_hold_state: got %b, want 1000", key_state);
    end
    key_in[3] = 1'b1; repeat (3) tick();
    key_in[3] = 1'b0; repeat (4) tick();
    key_in[3] = 1'b1;
    fc = -1; diff = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (key_state[3] === 1'b0 && fc < 0) fc = c;
      if (key_press !== m_press) diff++;
    end
    n_cmp++;
    if (fc != 12) begin
      n_bad++;
      $display("FAIL release_latency: got %0d cycles, want 12", fc);
    end
    n_cmp++;
    if (diff != 0) begin
      n_bad++;
      $display("FAIL release_no_pulse: got %0d cycles of unexpected press, want 0", diff);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_repeat();
    int fp;
    int offs[$];
    int want[$];
`ifdef KEY_REPEAT_EN
    want.push_back(30); want.push_back(40); want.push_back(50);
    want.push_back(60); want.push_back(70);
`endif
    release_all();
    key_in = 4'b1110;
    fp = -1;
    for (int c = 1; c <= 20 && fp < 0; c++) begin
      tick();
      if (key_press[0] === 1'b1) fp = c;
    end
    n_cmp++;
    if (fp != 12) begin
      n_bad++;
      $display("FAIL repeat_initial: got %0d cycles, want 12", fp);
    end
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (key_press[0] === 1'b1) offs.push_back(c);
    end
    n_cmp++;
    if (offs.size() != want.size()) begin
      n_bad++;
      $display("FAIL repeat_count: got %0d pulses, want %0d", offs.size(), want.size());
    end else begin
      for (int k = 0; k < want.size(); k++) begin
        n_cmp++;
        if (offs[k] != want[k]) begin
          n_bad++;
          $display("FAIL repeat_offset[%0d]: got +%0d, want +%0d", k, offs[k], want[k]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_random();
    int dur [4];
    int shown;
    shown = 0;
    release_all();
    for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 25);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          key_in[i] = ~key_in[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 120)
                                                : $urandom_range(1, 25);
        end
      end
      if (c == 2000) begin
        sys_rst = 1'b1;
        model_reset();
      end
      if (c == 2003) sys_rst = 1'b0;
      tick();
      n_cmp++;
      if ({key_state, key_press, key_valid, key_code} !==
          {m_level, m_press, m_valid, m_code}) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random[%0d]: got state=%b press=%b valid=%b code=%0d, want state=%b press=%b valid=%b code=%0d",
                   c, key_state, key_press, key_valid, key_code,
                   m_level, m_press, m_valid, m_code);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    model_reset();
    @(negedge sys_clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
